// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and helpers for the two-master memory arbiter.
// Optional build macro used by this slice: MEM_ARB_FIXED_PRIO_EN.
package mem_arb_pkg;

    localparam int MID_W     = 1;
    localparam logic [MID_W-1:0] M_CPU = 1'b0;
    localparam logic [MID_W-1:0] M_DMA = 1'b1;
    localparam int DEPTH_DEF = 4;

    // Number of bits needed to index v entries (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: one request/response bus. The requester drives the request
// fields; the responder drives accept/busy/ready/rdata.
interface mem_arb_if #(
    parameter int AW = 32
);
    logic          oe;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    we;
    logic          accept;
    logic          busy;
    logic          ready;
    logic [31:0]   rdata;

    modport master (
        output oe, addr, wdata, we,
        input  accept, busy, ready, rdata
    );

    modport slave (
        input  oe, addr, wdata, we,
        output accept, busy, ready, rdata
    );
endinterface

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: in-order record of which master issued each outstanding
// access. Push and pop may happen together, including while full.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [MID_W-1:0]      push_tag,
    input  logic                  pop,
    output logic [MID_W-1:0]      pop_tag,
    output logic [clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);
    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [MID_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Tag storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_tag;
    end

    assign pop_tag = mem[rptr];
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory/MMIO port between the processor data port
// (m0) and a DMA/loader port (m1). Responses return in order and are steered
// back to the issuing master via a tag FIFO.
// Build macro MEM_ARB_FIXED_PRIO_EN: m0 always wins ties (no round robin).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = 32
) (
    input  logic clk,
    input  logic rst,
    mem_arb_if.slave  m0,
    mem_arb_if.slave  m1,
    mem_arb_if.master s,
    output logic err
);
    logic                  gnt0;
    logic                  gnt1;
    logic                  room;
    logic                  push;
    logic                  pop;
    logic [MID_W-1:0]      push_tag;
    logic [MID_W-1:0]      head_tag;
    logic [clog2(DEPTH):0] fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [AW-1:0]         addr_mux;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [MID_W-1:0]      last_grant;
`endif

    // A response retiring this cycle frees its slot for a new request.
    assign room = !fifo_full || s.ready;

    // Grant selection: single requester wins; ties resolved by priority policy.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && room && !s.busy) begin
            if (m0.oe && !m1.oe) begin
                gnt0 = 1'b1;
            end else if (m1.oe && !m0.oe) begin
                gnt1 = 1'b1;
            end else if (m0.oe && m1.oe) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                gnt0 = 1'b1;
`else
                if (last_grant == M_DMA) gnt0 = 1'b1;
                else                     gnt1 = 1'b1;
`endif
            end
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Remember the last winner so the other master wins the next tie.
    always_ff @(posedge clk) begin
        if (!rst)              last_grant <= M_DMA;
        else if (gnt0 || gnt1) last_grant <= gnt1 ? M_DMA : M_CPU;
    end
`endif

    // Request path towards the slave; idle cycles still show m0's fields.
    assign addr_mux = gnt1 ? m1.addr : m0.addr;
    assign s.oe     = gnt0 || gnt1;
    assign s.addr   = addr_mux;
    assign s.wdata  = gnt1 ? m1.wdata : m0.wdata;
    assign s.we     = gnt1 ? m1.we : (gnt0 ? m0.we : 4'h0);

    assign m0.accept = gnt0;
    assign m1.accept = gnt1;
    assign m0.busy   = m0.oe && !gnt0;
    assign m1.busy   = m1.oe && !gnt1;

    assign push     = gnt0 || gnt1;
    assign push_tag = gnt1 ? M_DMA : M_CPU;

    // Responses are only meaningful while something is outstanding.
    assign pop       = rst && s.ready && (fifo_count != '0);
    assign m0.ready  = pop && (head_tag == M_CPU);
    assign m1.ready  = pop && (head_tag == M_DMA);
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

    mem_arb_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .pop_tag  (head_tag),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk) begin
        if (!rst)                    err <= 1'b0;
        else if (s.ready && fifo_empty) err <= 1'b1;
    end

endmodule
